pfa_pipe: RTL and testbench

PFA_PIPE -- requirements
Module: pfa_pipe

---
 rtl/pfa_pkg.sv | 21 ++
 rtl/pfa_cell.sv | 17 +
 rtl/pfa_pipe.sv | 162 ++++++++++++++++
 tb/tb_pfa_pipe.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pfa_pkg.sv
// pfa_pkg: shared sizing helpers for the pipelined prefix adder.
// Holds the width limits, clog2 and the tree stage-count function.
package pfa_pkg;

    localparam int WIDTH_MIN = 8;
    localparam int WIDTH_MAX = 64;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int stages(input int w, input int lps);
        return (clog2(w) + lps - 1) / lps;
    endfunction

endpackage

// File: rtl/pfa_cell.sv
// pfa_cell: one (g,a) prefix combine node of the carry tree.
// HAS_A=0 drops the alive term where the group already reaches bit 0.
module pfa_cell #(
    parameter bit HAS_A = 1'b1
) (
    input  logic gh,
    input  logic ah,
    input  logic gl,
    input  logic al,
    output logic g,
    output logic a
);

    assign g = gh | (ah & gl);
    assign a = HAS_A ? (ah & al) : 1'b0;

endmodule

// File: rtl/pfa_pipe.sv
// pfa_pipe: pipelined Sklansky prefix adder/subtractor, valid/ready flow.
// Define PFA_OVF_EN to add the signed-overflow output and its pipeline.
module pfa_pipe
    import pfa_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int LVL_PER_STAGE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef PFA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int L = clog2(WIDTH);
    localparam int S = stages(WIDTH, LVL_PER_STAGE);

    logic             en;
    logic [WIDTH-1:0] yp;
    logic [WIDTH-1:0] cy;
    logic [WIDTH-1:0] sn;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;
    assign yp       = sub ? ~y : y;

    genvar t, k, i;

    for (t = 0; t < S; t++) begin : g_stg
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] p;
        logic             c;
        logic             v;
`ifdef PFA_OVF_EN
        logic             xs;
`endif
        if (t == 0) begin : g_ld
            // operand stage: per-bit generate/alive/propagate
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v <= 1'b0;
                    g <= '0;
                    a <= '0;
                    p <= '0;
                    c <= 1'b0;
                end else if (en) begin
                    v <= in_valid;
                    g <= x & yp;
                    a <= x | yp;
                    p <= x ^ yp;
                    c <= cin ^ sub;
                end
            end
`ifdef PFA_OVF_EN
            // x sign rides along for the overflow decision
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) xs <= 1'b0;
                else if (en) xs <= x[WIDTH-1];
            end
`endif
        end else begin : g_ld
            // tree stage boundary: capture partial prefixes
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v <= 1'b0;
                    g <= '0;
                    a <= '0;
                    p <= '0;
                    c <= 1'b0;
                end else if (en) begin
                    v <= g_stg[t-1].v;
                    g <= g_lvl[t*LVL_PER_STAGE-1].go;
                    a <= g_lvl[t*LVL_PER_STAGE-1].ao;
                    p <= g_stg[t-1].p;
                    c <= g_stg[t-1].c;
                end
            end
`ifdef PFA_OVF_EN
            // x sign rides along for the overflow decision
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) xs <= 1'b0;
                else if (en) xs <= g_stg[t-1].xs;
            end
`endif
        end
    end

    for (k = 0; k < L; k++) begin : g_lvl
        logic [WIDTH-1:0] gi;
        logic [WIDTH-1:0] ai;
        logic [WIDTH-1:0] go;
        logic [WIDTH-1:0] ao;
        if (k == 0) begin : g_src
            assign gi = {g_stg[0].g[WIDTH-1:1],
                         g_stg[0].g[0] | (g_stg[0].a[0] & g_stg[0].c)};
            assign ai = g_stg[0].a;
        end else if (k % LVL_PER_STAGE == 0) begin : g_src
            assign gi = g_stg[k/LVL_PER_STAGE].g;
            assign ai = g_stg[k/LVL_PER_STAGE].a;
        end else begin : g_src
            assign gi = g_lvl[k-1].go;
            assign ai = g_lvl[k-1].ao;
        end
        for (i = 0; i < WIDTH; i++) begin : g_bit
            if (((i >> k) & 1) == 1) begin : g_c
                localparam int J = ((i >> k) << k) - 1;
                pfa_cell #(
                    .HAS_A((i >= (2 << k)) ? 1'b1 : 1'b0)
                ) u_cell (
                    .gh(gi[i]),
                    .ah(ai[i]),
                    .gl(gi[J]),
                    .al(ai[J]),
                    .g (go[i]),
                    .a (ao[i])
                );
            end else begin : g_c
                assign go[i] = gi[i];
                assign ao[i] = ai[i];
            end
        end
    end

    assign cy = g_lvl[L-1].go;
    assign sn = g_stg[S-1].p ^ {cy[WIDTH-2:0], g_stg[S-1].c};

    // result stage: sum bits, carry out and valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
        end else if (en) begin
            out_valid <= g_stg[S-1].v;
            s         <= sn;
            cout      <= cy[WIDTH-1];
        end
    end

`ifdef PFA_OVF_EN
    // overflow: operand signs agree but result sign differs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf <= 1'b0;
        else if (en) ovf <= ~g_stg[S-1].p[WIDTH-1] &
                            (sn[WIDTH-1] ^ g_stg[S-1].xs);
    end
`endif

endmodule

// File: tb/tb_pfa_pipe.sv
// tb_pfa_pipe: checks pfa_pipe at 32/1 and 8/3 against an arithmetic model.
// Honours PFA_OVF_EN for the overflow port.
module tb_pfa_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        v32, r32, c32, b32, ov32, or32, co32;
    logic [31:0] x32, y32, s32;
    logic        v8, r8, c8, b8, ov8, or8, co8;
    logic [7:0]  x8, y8, s8;
`ifdef PFA_OVF_EN
    logic        of32, of8;
`endif

    pfa_pipe u32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v32), .in_ready(r32),
        .x(x32), .y(y32), .cin(c32), .sub(b32),
        .out_valid(ov32), .out_ready(or32),
        .s(s32), .cout(co32)
`ifdef PFA_OVF_EN
        , .ovf(of32)
`endif
    );

    pfa_pipe #(.WIDTH(8), .LVL_PER_STAGE(3)) u8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v8), .in_ready(r8),
        .x(x8), .y(y8), .cin(c8), .sub(b8),
        .out_valid(ov8), .out_ready(or8),
        .s(s8), .cout(co8)
`ifdef PFA_OVF_EN
        , .ovf(of8)
`endif
    );

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        o;
    } exp_t;

    function automatic exp_t model(input int w, input logic [31:0] a,
                                   input logic [31:0] b, input logic ci,
                                   input logic sb);
        exp_t e;
        logic [63:0] m, ua, ub, cu, r;
        longint sa, sv, sr, hi;
        m  = (64'd1 << w) - 64'd1;
        ua = {32'd0, a} & m;
        ub = {32'd0, b} & m;
        cu = {63'd0, ci};
        if (sb) begin
            r   = ua - ub - cu;
            e.c = (ua >= ub + cu);
        end else begin
            r   = ua + ub + cu;
            e.c = r[w];
        end
        e.s = r[31:0] & m[31:0];
        hi  = longint'(m >> 1);
        sa  = (ua > (m >> 1)) ? longint'(ua) - longint'(m) - 1 : longint'(ua);
        sv  = (ub > (m >> 1)) ? longint'(ub) - longint'(m) - 1 : longint'(ub);
        sr  = sb ? sa - sv - longint'(cu) : sa + sv + longint'(cu);
        e.o = (sr > hi) || (sr < -hi - 1);
        return e;
    endfunction

    task automatic test_reset();
        v32 = 0; x32 = 0; y32 = 0; c32 = 0; b32 = 0; or32 = 1;
        v8 = 0; x8 = 0; y8 = 0; c8 = 0; b8 = 0; or8 = 1;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (ov32 !== 1'b0) begin
            failures++; $display("FAIL reset_ov32: got %b want 0", ov32);
        end
        checks++;
        if (r32 !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready: got %b want 1", r32);
        end
        checks++;
        if (s32 !== 32'd0 || co32 !== 1'b0) begin
            failures++;
            $display("FAIL reset_s32: got s=%h c=%b want 0/0", s32, co32);
        end
        checks++;
        if (ov8 !== 1'b0 || s8 !== 8'd0 || co8 !== 1'b0) begin
            failures++;
            $display("FAIL reset_u8: got v=%b s=%h c=%b want 0", ov8, s8, co8);
        end
`ifdef PFA_OVF_EN
        checks++;
        if (of32 !== 1'b0 || of8 !== 1'b0) begin
            failures++; $display("FAIL reset_ovf: got %b/%b want 0", of32, of8);
        end
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add32(input string nm, input logic [31:0] a,
                              input logic [31:0] b, input logic ci,
                              input logic sb, input logic [31:0] xs,
                              input logic xc, input logic xo);
        int lat;
        or32 = 1;
        @(posedge clk); #1;
        x32 = a; y32 = b; c32 = ci; b32 = sb; v32 = 1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            v32 = 0;
        end while (!ov32 && lat < 20);
        checks++;
        if (lat != 6) begin
            failures++; $display("FAIL %s_latency: got %0d want 6", nm, lat);
        end
        checks++;
        if (s32 !== xs || co32 !== xc) begin
            failures++;
            $display("FAIL %s: got s=%h c=%b want s=%h c=%b",
                     nm, s32, co32, xs, xc);
        end
`ifdef PFA_OVF_EN
        checks++;
        if (of32 !== xo) begin
            failures++; $display("FAIL %s_ovf: got %b want %b", nm, of32, xo);
        end
`else
        if (xo === 1'bx) $display("note: overflow expectation undefined");
`endif
    endtask

    task automatic test_add8();
        int lat;
        @(posedge clk); #1;
        x8 = 8'hFF; y8 = 8'h01; c8 = 1; b8 = 0; v8 = 1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            v8 = 0;
        end while (!ov8 && lat < 20);
        checks++;
        if (lat != 2) begin
            failures++; $display("FAIL add8_latency: got %0d want 2", lat);
        end
        checks++;
        if (s8 !== 8'h01 || co8 !== 1'b1) begin
            failures++;
            $display("FAIL add8: got s=%h c=%b want s=01 c=1", s8, co8);
        end
    endtask

    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e;
        logic [31:0] xa[8];
        logic [31:0] ya[8];
        logic ca[8];
        logic ba[8];
        int sent, got, cyc, extra;
        logic held, hc;
        logic [31:0] hs;
        sent = 0; got = 0; cyc = 0; extra = 0;
        held = 0; hc = 0; hs = 0;
        for (int i = 0; i < 8; i++) begin
            xa[i] = $urandom;
            ya[i] = $urandom;
            ca[i] = 1'($urandom_range(1, 0));
            ba[i] = 1'($urandom_range(1, 0));
        end
        while (got < 8 && cyc < 80) begin
            @(posedge clk); #1;
            or32 = !(cyc >= 7 && cyc <= 9);
            if (sent < 8) begin
                v32 = 1; x32 = xa[sent]; y32 = ya[sent];
                c32 = ca[sent]; b32 = ba[sent];
            end else begin
                v32 = 0;
            end
            @(negedge clk);
            checks++;
            if (r32 !== (!ov32 || or32)) begin
                failures++;
                $display("FAIL stream_in_ready cyc %0d: got %b ov=%b or=%b",
                         cyc, r32, ov32, or32);
            end
            if (held) begin
                checks++;
                if (ov32 !== 1'b1 || s32 !== hs || co32 !== hc) begin
                    failures++;
                    $display("FAIL stream_hold cyc %0d: got v=%b s=%h c=%b want 1 %h %b",
                             cyc, ov32, s32, co32, hs, hc);
                end
            end
            if (v32 && r32) begin
                q.push_back(model(32, x32, y32, c32, b32));
                sent++;
            end
            if (ov32 && or32) begin
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL stream_extra: got s=%h want none", s32);
                end else begin
                    e = q.pop_front();
                    if (s32 !== e.s || co32 !== e.c) begin
                        failures++;
                        $display("FAIL stream_result %0d: got s=%h c=%b want s=%h c=%b",
                                 got, s32, co32, e.s, e.c);
                    end
`ifdef PFA_OVF_EN
                    checks++;
                    if (of32 !== e.o) begin
                        failures++;
                        $display("FAIL stream_ovf %0d: got %b want %b", got, of32, e.o);
                    end
`endif
                end
                got++;
            end
            held = ov32 && !or32;
            hs = s32;
            hc = co32;
            cyc++;
        end
        v32 = 0; or32 = 1;
        checks++;
        if (got != 8 || sent != 8) begin
            failures++;
            $display("FAIL stream_count: got %0d/%0d want 8/8", got, sent);
        end
        repeat (8) begin
            @(negedge clk);
            if (ov32 !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++; $display("FAIL stream_dup: got %0d extra want 0", extra);
        end
    endtask

    task automatic test_flush();
        int k, seen;
        k = 0; seen = 0;
        or32 = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            v32 = 1; x32 = $urandom; y32 = $urandom;
            c32 = 1'($urandom_range(1, 0));
            b32 = 1'($urandom_range(1, 0));
        end
        @(posedge clk); #1;
        v32 = 0;
        while (!ov32 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (ov32 !== 1'b1) begin
            failures++; $display("FAIL flush_setup: got %b want 1", ov32);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (ov32 !== 1'b0 || s32 !== 32'd0 || co32 !== 1'b0) begin
            failures++;
            $display("FAIL flush_clear: got v=%b s=%h c=%b want 0", ov32, s32, co32);
        end
        checks++;
        if (r32 !== 1'b1) begin
            failures++; $display("FAIL flush_in_ready: got %b want 1", r32);
        end
        @(negedge clk);
        rst_n = 1'b1;
        or32 = 1;
        repeat (12) begin
            @(negedge clk);
            if (ov32 !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++; $display("FAIL flush_stale: got %0d results want 0", seen);
        end
    endtask

    task automatic test_sweep8();
        exp_t q[$];
        exp_t e;
        int n, got, cyc, bad;
        logic [7:0] bx, by, bs;
        n = 0; got = 0; cyc = 0; bad = 0;
        bx = 0; by = 0; bs = 0;
        or8 = 1;
        while (got < 65536 && cyc < 70000) begin
            @(posedge clk); #1;
            if (n < 65536) begin
                v8 = 1; x8 = 8'(n >> 8); y8 = 8'(n);
                c8 = 1'($urandom_range(1, 0));
                b8 = 1'($urandom_range(1, 0));
            end else begin
                v8 = 0;
            end
            @(negedge clk);
            if (v8 && r8) begin
                q.push_back(model(8, {24'd0, x8}, {24'd0, y8}, c8, b8));
                n++;
            end
            if (ov8 && or8) begin
                if (q.size() == 0) begin
                    bad++;
                end else begin
                    e = q.pop_front();
                    if (s8 !== e.s[7:0] || co8 !== e.c
`ifdef PFA_OVF_EN
                        || of8 !== e.o
`endif
                       ) begin
                        if (bad == 0) begin
                            bx = 8'(got >> 8); by = 8'(got); bs = s8;
                        end
                        bad++;
                    end
                end
                got++;
            end
            cyc++;
        end
        v8 = 0;
        checks++;
        if (bad != 0 || got != 65536) begin
            failures++;
            $display("FAIL sweep8: got %0d bad of %0d (first x=%h y=%h s=%h) want 0 of 65536",
                     bad, got, bx, by, bs);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add32("inc_wrap", 32'hFFFFFFFF, 32'h1, 0, 0, 32'h0, 1, 0);
        test_add32("sub_5_7", 32'd5, 32'd7, 0, 1, 32'hFFFFFFFE, 0, 0);
        test_add32("sub_7_5", 32'd7, 32'd5, 0, 1, 32'h2, 1, 0);
        test_add32("pos_ovf", 32'h7FFFFFFF, 32'h1, 0, 0, 32'h80000000, 0, 1);
        test_add32("neg_ovf", 32'h80000000, 32'h80000000, 0, 0, 32'h0, 1, 1);
        test_add32("sub_borrow_in", 32'h0, 32'h0, 1, 1, 32'hFFFFFFFF, 0, 0);
        test_add32("add_all_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 1, 0);
        test_add8();
        test_back_to_back();
        test_flush();
        test_sweep8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
